seq_signed_alu: RTL
===================

Name: seq_signed_alu

Overview:
Multi-cycle, parametrised signed arithmetic unit for the calculator datapath. It supersedes the repeated-addition and repeated-subtraction ALU. It accepts two's-complement binary operands of WIDTH bits under a start/busy/done handshake. Multiply uses a WIDTH-step shift-add; divide uses a WIDTH-step restoring algorithm. Results are returned as sign + magnitude, ready for the binary-to-BCD display path, with explicit divide-by-zero and illegal-op flags.

Parameters:
WIDTH, 12, operand width in bits (two's complement); must be >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when busy=0
operator  input  4  opcode: C=Divide, D=Multiply, E=Subtract, F=Add
operand_a  input  WIDTH  first operand / dividend, two's complement
operand_b  input  WIDTH  second operand / divisor, two's complement
busy  output  1  high from the cycle after acceptance until the done cycle, inclusive
done  output  1  single-cycle pulse: results valid
result_mag  output  2*WIDTH  magnitude of the sum, difference, product or quotient
sign_out  output  1  1 = result negative; never 1 when result_mag is 0
remainder_mag  output  WIDTH  magnitude of the divide remainder; 0 for other ops
rem_sign  output  1  remainder sign (equals dividend sign); 0 when remainder is 0
div_by_zero  output  1  set with done when Divide and operand_b = 0
illegal_op  output  1  set with done when operator is 0x0..0xB

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0; internal accumulators and counter 0. Asserting reset mid-operation aborts the operation; no done pulse follows.
- FSM states:
  - IDLE: on start=1, latch operands and operator; capture sa = operand_a MSB, sb = operand_b MSB; capture |a| and |b| as WIDTH-bit unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) must not overflow. Go to EXEC.
  - EXEC: Add/Sub, illegal op, or Divide with b = 0: compute in one cycle, then go to FIN. Multiply/Divide otherwise: iterate.
  - ITER: one step per cycle, counter runs 0..WIDTH-1; after step WIDTH-1, go to FIN.
  - FIN: register outputs; pulse done=1; return to IDLE.
- Latency, start cycle to done cycle: Add/Sub/illegal/div-by-zero = 2 cycles. Multiply/Divide = WIDTH+2 cycles. busy=1 in every cycle between.
- start while busy=1: ignored, with no effect on the operation in flight. start in the FIN cycle is also ignored. Back-to-back throughput is one op per (latency+1) cycles.
- Add/Sub: operands sign-extended to 2*WIDTH+1 bits before the operation. sign_out = MSB of the sum or difference; result_mag = its absolute value. No overflow is possible.
- Multiply: unsigned shift-add of |a|*|b| into a 2*WIDTH accumulator. sign_out = sa^sb, forced to 0 if the product is 0.
- Divide: restoring division of |a| by |b| (truncating toward zero). Quotient is zero-extended into result_mag. sign_out = sa^sb, forced to 0 if the quotient is 0. remainder_mag = |a| mod |b|. rem_sign = sa, forced to 0 if the remainder is 0.
- Divide by zero: result_mag=0, remainder_mag=0, sign_out=0, rem_sign=0, div_by_zero=1.
- Illegal op: all results 0, illegal_op=1.
- Flags are valid with done. All result outputs hold their values until the next FIN overwrites them or reset.

Decomposition:
- Package calc_pkg: opcode constants OP_DIV=4'hC, OP_MUL=4'hD, OP_SUB=4'hE, OP_ADD=4'hF; FSM state encoding IDLE/EXEC/ITER/FIN. The existing ALU and the keypad FSM share these.
- One sub-module, abs_sign (combinational, parametrised by WIDTH): two's-complement input -> unsigned magnitude + sign bit. Instantiate once per operand.
- Reuse the same abs_sign logic, widened, for the Add/Sub result.

Test Plan:
1. WIDTH=12, Add 999 + (-1000) -> done on cycle 2, result_mag=1, sign_out=1, flags 0; then Sub 5-5 -> result_mag=0, sign_out=0.
2. Multiply -999 x 999 -> done on cycle 14, result_mag=998001, sign_out=1; then -2048 x -2048 -> result_mag=4194304, sign_out=0.
3. Divide -7 / 2 -> result_mag=3, sign_out=1, remainder_mag=1, rem_sign=1; then 6 / -3 -> result_mag=2, sign_out=1, remainder_mag=0, rem_sign=0.
4. Divide 5 / 0 -> done on cycle 2, div_by_zero=1, result_mag=0; then operator=4'h3 -> illegal_op=1, results 0.
5. Handshake: start Multiply 3x4, pulse start with Add on cycle 5 -> ignored; single done on cycle 14 with result_mag=12; busy high cycles 1..14.
6. Reset low on cycle 6 of a Divide -> all outputs 0 immediately (asynchronously), no done pulse; a fresh Add 1+1 afterwards -> result_mag=2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcodes and the sequencing FSM state encoding.
package calc_pkg;

    localparam logic [3:0] OP_DIV = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_SUB = 4'hE;
    localparam logic [3:0] OP_ADD = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        FIN  = 2'd3
    } calc_state_e;

endpackage

// File: rtl/abs_sign.sv
// Two's-complement value to unsigned magnitude plus sign; the most negative value maps to 2^(WIDTH-1).
module abs_sign #(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mag_c,
    output logic             neg_c
);

    assign neg_c = value[WIDTH-1];
    assign mag_c = neg_c ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_signed_alu.sv
// Multi-cycle signed ALU: single-cycle add/sub, shift-add multiply, restoring divide,
// results returned as sign + magnitude under a start/busy/done handshake.
module seq_signed_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           operator,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_mag,
    output logic                 sign_out,
    output logic [WIDTH-1:0]     remainder_mag,
    output logic                 rem_sign,
    output logic                 div_by_zero,
    output logic                 illegal_op
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned XW    = 2 * WIDTH + 1;

    calc_state_e        state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d, shreg_q, shreg_d;
    logic [WIDTH-1:0]   wreg_q, wreg_d, rem_q, rem_d;

    logic               busy_q, busy_d, done_q, done_d;
    logic [PW-1:0]      result_mag_q, result_mag_d;
    logic               sign_out_q, sign_out_d;
    logic [WIDTH-1:0]   rem_mag_q, rem_mag_d;
    logic               rem_sign_q, rem_sign_d;
    logic               dbz_q, dbz_d, ill_q, ill_d;

    logic [WIDTH-1:0]   abs_a_mag, abs_b_mag;
    logic               abs_a_neg, abs_b_neg;

    abs_sign #(.WIDTH(WIDTH)) u_abs_a (.value(operand_a), .mag_c(abs_a_mag), .neg_c(abs_a_neg));
    abs_sign #(.WIDTH(WIDTH)) u_abs_b (.value(operand_b), .mag_c(abs_b_mag), .neg_c(abs_b_neg));

    // Add/sub in 2*WIDTH+1 bits so the result can never overflow.
    logic [XW-1:0]      ext_a, ext_b, as_res, as_mag;
    logic               as_neg;

    assign ext_a  = {{(WIDTH + 1){a_q[WIDTH-1]}}, a_q};
    assign ext_b  = {{(WIDTH + 1){b_q[WIDTH-1]}}, b_q};
    assign as_res = (op_q == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);

    abs_sign #(.WIDTH(XW)) u_abs_r (.value(as_res), .mag_c(as_mag), .neg_c(as_neg));

    logic [PW-1:0]      acc_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic               last_step;

    assign acc_next  = acc_q + (wreg_q[0] ? shreg_q : '0);
    assign div_shift = {rem_q, wreg_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b_q};
    assign rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, mag_b_q}) : WIDTH'(div_shift);
    assign quo_next  = {wreg_q[WIDTH-2:0], div_ge};
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    logic               fin;
    logic [PW-1:0]      fin_mag;
    logic               fin_sign;
    logic [WIDTH-1:0]   fin_rem;
    logic               fin_rsign, fin_dbz, fin_ill;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shreg_d      = shreg_q;
        wreg_d       = wreg_q;
        rem_d        = rem_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        result_mag_d = result_mag_q;
        sign_out_d   = sign_out_q;
        rem_mag_d    = rem_mag_q;
        rem_sign_d   = rem_sign_q;
        dbz_d        = dbz_q;
        ill_d        = ill_q;
        fin          = 1'b0;
        fin_mag      = '0;
        fin_sign     = 1'b0;
        fin_rem      = '0;
        fin_rsign    = 1'b0;
        fin_dbz      = 1'b0;
        fin_ill      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = operator;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    mag_a_d = abs_a_mag;
                    mag_b_d = abs_b_mag;
                    sa_d    = abs_a_neg;
                    sb_d    = abs_b_neg;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = '0;
                if (op_q < OP_DIV) begin
                    fin     = 1'b1;
                    fin_ill = 1'b1;
                end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                    fin      = 1'b1;
                    fin_mag  = PW'(as_mag);
                    fin_sign = as_neg;
                end else if (op_q == OP_DIV && mag_b_q == '0) begin
                    fin     = 1'b1;
                    fin_dbz = 1'b1;
                end else if (op_q == OP_MUL) begin
                    acc_d   = '0;
                    shreg_d = PW'(mag_a_q);
                    wreg_d  = mag_b_q;
                    state_d = ITER;
                end else begin
                    rem_d   = '0;
                    wreg_d  = mag_a_q;
                    state_d = ITER;
                end
            end
            ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d   = acc_next;
                    shreg_d = shreg_q << 1;
                    wreg_d  = wreg_q >> 1;
                    if (last_step) begin
                        fin      = 1'b1;
                        fin_mag  = acc_next;
                        fin_sign = (sa_q ^ sb_q) && (acc_next != '0);
                    end
                end else begin
                    rem_d  = rem_next;
                    wreg_d = quo_next;
                    if (last_step) begin
                        fin       = 1'b1;
                        fin_mag   = PW'(quo_next);
                        fin_sign  = (sa_q ^ sb_q) && (quo_next != '0);
                        fin_rem   = rem_next;
                        fin_rsign = sa_q && (rem_next != '0);
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Results and done are registered on the way into FIN, so done coincides with FIN.
        if (fin) begin
            state_d      = FIN;
            done_d       = 1'b1;
            result_mag_d = fin_mag;
            sign_out_d   = fin_sign;
            rem_mag_d    = fin_rem;
            rem_sign_d   = fin_rsign;
            dbz_d        = fin_dbz;
            ill_d        = fin_ill;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            shreg_q      <= '0;
            wreg_q       <= '0;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_mag_q <= '0;
            sign_out_q   <= 1'b0;
            rem_mag_q    <= '0;
            rem_sign_q   <= 1'b0;
            dbz_q        <= 1'b0;
            ill_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shreg_q      <= shreg_d;
            wreg_q       <= wreg_d;
            rem_q        <= rem_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_mag_q <= result_mag_d;
            sign_out_q   <= sign_out_d;
            rem_mag_q    <= rem_mag_d;
            rem_sign_q   <= rem_sign_d;
            dbz_q        <= dbz_d;
            ill_q        <= ill_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result_mag    = result_mag_q;
    assign sign_out      = sign_out_q;
    assign remainder_mag = rem_mag_q;
    assign rem_sign      = rem_sign_q;
    assign div_by_zero   = dbz_q;
    assign illegal_op    = ill_q;

endmodule
